// File: rtl/c1_pixel_feeder_if.sv
// Pixel stream from c1_pixel_feeder into the C1 layer pixel input.
interface c1_pixel_feeder_if #(
  parameter int DATA_W = 8
);
  logic                     pixel_out_valid;
  logic                     pixel_out_ready;
  logic signed [DATA_W-1:0] pixel_out;
  logic [4:0]               o_row;
  logic [4:0]               o_col;
  logic                     o_frame_start;
  logic                     o_frame_end;

  modport master (
    output pixel_out_valid, pixel_out, o_row, o_col, o_frame_start, o_frame_end,
    input  pixel_out_ready
  );

  modport slave (
    input  pixel_out_valid, pixel_out, o_row, o_col, o_frame_start, o_frame_end,
    output pixel_out_ready
  );
endinterface

// File: rtl/c1_pixel_feeder.sv
// C1 pixel feeder: host-loaded frame buffer streamed in raster order with backpressure.
// Define C1_FEED_CHECKSUM_EN to build the per-frame pixel checksum on o_checksum.
module c1_pixel_feeder #(
  parameter int IMG_W       = 32,
  parameter int IMG_H       = 32,
  parameter int DATA_W      = 8,
  parameter int START_DELAY = 20,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  c1_pixel_feeder_if.master pix,
  output logic              o_busy,
  output logic              o_done,
  output logic [15:0]       o_checksum
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = ADDR_W + 1;
  localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, STREAM, DONE} state_t;

  state_t            state, state_nxt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [CNT_W-1:0]  rd_cnt;
  logic              rd_en, rd_vld;
  logic [DATA_W-1:0] mem [NPIX];
  logic [DATA_W-1:0] mem_q, skid_q, out_q;
  logic              skid_vld, out_vld;
  logic [4:0]        row, col;
  logic              xfer, last_pix, start_ok, abort_ok, slot_free;

  assign start_ok  = (state == IDLE) && i_start;
  assign abort_ok  = (state != IDLE) && i_abort;
  assign xfer      = out_vld && pix.pixel_out_ready;
  assign slot_free = !out_vld || xfer;
  assign last_pix  = (row == 5'(IMG_H - 1)) && (col == 5'(IMG_W - 1));

  // Reads run ahead only while the output slot is free or draining; the one
  // read that can still be in flight on a stall lands in the skid register.
  assign rd_en = (state == STREAM) && (rd_cnt < CNT_W'(NPIX)) && slot_free;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort_ok) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (i_start) state_nxt = (START_DELAY == 0) ? STREAM : DELAY;
        DELAY:   if (dly_cnt <= DLY_W'(1)) state_nxt = STREAM;
        STREAM:  if (xfer && last_pix) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state != IDLE);
    o_done = (state == DONE);
  end

  // ---------------- weight-load delay ----------------
  always_ff @(posedge clk) begin
    if (reset || abort_ok)                      dly_cnt <= '0;
    else if (start_ok)                          dly_cnt <= DLY_W'(START_DELAY);
    else if (state == DELAY && dly_cnt != '0)   dly_cnt <= dly_cnt - DLY_W'(1);
  end

  // ---------------- frame buffer ----------------
  always_ff @(posedge clk) begin
    if (wr_en && (state == IDLE) && ({1'b0, wr_addr} < CNT_W'(NPIX)))
      mem[wr_addr] <= wr_data;
    if (rd_en)
      mem_q <= mem[rd_cnt[ADDR_W-1:0]];
  end

  // ---------------- read / skid / output control ----------------
  always_ff @(posedge clk) begin
    if (reset || abort_ok) begin
      rd_cnt   <= '0;
      rd_vld   <= 1'b0;
      skid_vld <= 1'b0;
      out_vld  <= 1'b0;
      row      <= '0;
      col      <= '0;
    end else begin
      rd_vld <= rd_en;
      if (state == DONE) rd_cnt <= '0;
      else if (rd_en)    rd_cnt <= rd_cnt + CNT_W'(1);

      if (slot_free) begin
        out_vld  <= skid_vld || rd_vld;
        skid_vld <= 1'b0;
      end else if (rd_vld) begin
        skid_vld <= 1'b1;
      end

      if (xfer) begin
        if (col == 5'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == 5'(IMG_H - 1)) ? 5'd0 : row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (slot_free) begin
      if (skid_vld)    out_q <= skid_q;
      else if (rd_vld) out_q <= mem_q;
    end else if (rd_vld) begin
      skid_q <= mem_q;
    end
  end

  assign pix.pixel_out_valid = out_vld;
  assign pix.pixel_out       = out_q;
  assign pix.o_row           = row;
  assign pix.o_col           = col;
  assign pix.o_frame_start   = out_vld && (row == 5'd0) && (col == 5'd0);
  assign pix.o_frame_end     = out_vld && last_pix;

  // ---------------- optional frame checksum ----------------
`ifdef C1_FEED_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk) begin
    if (reset || start_ok) csum <= '0;
    else if (xfer)         csum <= csum + 16'($signed(out_q));
  end

  assign o_checksum = csum;
`else
  assign o_checksum = '0;
`endif

endmodule
